// File: rtl/obstacle_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler_pkg
// Shared definitions for the obstacle spawning logic:
//   - FSM state encoding of the scheduler
//   - LFSR width and feedback taps (x^16 + x^14 + x^13 + x^11 + 1)
//   - gap / spawn counter widths
//   - sprite instance index layout: small cactus = 0..NS-1, big = NS..NS+NB-1
// -----------------------------------------------------------------------------
package obstacle_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_PICK = 3'd2,
    ST_FIRE = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  localparam int          LFSR_W    = 16;
  // Tap mask: bit 15 <-> x^16, 13 <-> x^14, 12 <-> x^13, 10 <-> x^11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int GAP_W = 10;
  localparam int CNT_W = 16;

  // First instance index of a cactus type (big = 1 selects the big bank).
  function automatic int type_base(input logic big, input int ns);
    return big ? ns : 0;
  endfunction

  // Number of instances of a cactus type.
  function automatic int type_count(input logic big, input int ns, input int nb);
    return big ? nb : ns;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, shifting left with the feedback bit entering at bit 0.
// Reusable source of pseudo-random timing for game blocks.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset, loads SEED
//   i_en     in   shift enable; state holds while low
//   o_state  out  current 16-bit LFSR state
// SEED must be non-zero or the register locks up at all-zeros.
// -----------------------------------------------------------------------------
module lfsr16
  import obstacle_scheduler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb    = ^(r_state & LFSR_TAPS);
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {r_state[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
// Decides when the next cactus appears and which sprite instance launches it.
// Scroll ticks are counted down from a randomised gap; then a free instance of
// a pseudo-randomly drawn type gets a one-clock start pulse, the scheduler waits
// for that instance to drop its finish flag, and the next gap begins. Every
// SPEEDUP_EVERY acknowledged spawns the minimum gap shrinks toward GAP_FLOOR.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   run          in   game running; low returns the scheduler to idle
//   scroll_tick  in   one-clock pulse per one-column scroll step
//   finish_i     in   per-instance finish flags (1 = free / off-screen)
//   start_o      out  one-hot, one-clock start pulse to the chosen instance
//   spawn_cnt    out  acknowledged spawns since reset, saturating
//   cur_gap      out  minimum gap currently in force (scroll ticks)
//   stall        out  high while picking with no free instance
//   err          out  sticky: an instance never acknowledged its start
// -----------------------------------------------------------------------------
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int                NS            = 2,
  parameter int                NB            = 2,
  parameter int                MIN_GAP       = 200,
  parameter int                GAP_FLOOR     = 90,
  parameter int                GAP_STEP      = 10,
  parameter int                SPEEDUP_EVERY = 8,
  parameter int                RBITS         = 7,
  parameter int                ACK_TIMEOUT   = 1023,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             scroll_tick,
  input  logic [NS+NB-1:0] finish_i,
  output logic [NS+NB-1:0] start_o,
  output logic [CNT_W-1:0] spawn_cnt,
  output logic [GAP_W-1:0] cur_gap,
  output logic             stall,
  output logic             err
);

  localparam int NI     = NS + NB;
  localparam int SEL_W  = (NI > 1) ? $clog2(NI) : 1;
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int SPD_W  = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

  localparam logic [GAP_W-1:0]  P_MIN_GAP   = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0]  P_FLOOR     = GAP_W'(GAP_FLOOR);
  localparam logic [GAP_W-1:0]  P_STEP      = GAP_W'(GAP_STEP);
  localparam logic [GAP_W-1:0]  P_GAP_ONE   = GAP_W'(1);
  localparam logic [WAIT_W-1:0] P_WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [SPD_W-1:0]  P_SPD_LAST  = SPD_W'(SPEEDUP_EVERY - 1);
  localparam logic [CNT_W-1:0]  P_CNT_MAX   = '1;

  // Priority picker: lowest free index of the preferred type, otherwise the
  // lowest free index of the other type. Result is {found, index}.
  function automatic logic [SEL_W:0] pick_free(input logic [NI-1:0] fin, input logic big);
    logic             pref_hit;
    logic             alt_hit;
    logic [SEL_W-1:0] pref_idx;
    logic [SEL_W-1:0] alt_idx;
    int               pref_lo;
    int               pref_hi;
    pref_hit = 1'b0;
    alt_hit  = 1'b0;
    pref_idx = '0;
    alt_idx  = '0;
    pref_lo  = type_base(big, NS);
    pref_hi  = pref_lo + type_count(big, NS, NB);
    // Scan downward so the last hit written is the lowest index.
    for (int k = NI - 1; k >= 0; k--) begin
      if (fin[k]) begin
        if (k >= pref_lo && k < pref_hi) begin
          pref_hit = 1'b1;
          pref_idx = SEL_W'(k);
        end else begin
          alt_hit = 1'b1;
          alt_idx = SEL_W'(k);
        end
      end
    end
    if (pref_hit) begin
      return {1'b1, pref_idx};
    end else if (alt_hit) begin
      return {1'b1, alt_idx};
    end
    return '0;
  endfunction

  // Registers
  state_t            r_state;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [SEL_W-1:0]  r_sel;
  logic              r_type;
  logic              r_pick_first;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_spawn_cnt;
  logic [GAP_W-1:0]  r_cur_gap;
  logic              r_err;
  logic [SPD_W-1:0]  r_speed_cnt;

  // Next-state wires
  state_t            w_state_next;
  logic [GAP_W-1:0]  w_gap_next;
  logic [SEL_W-1:0]  w_sel_next;
  logic              w_type_next;
  logic              w_pick_first_next;
  logic [WAIT_W-1:0] w_wait_next;
  logic [CNT_W-1:0]  w_spawn_next;
  logic [GAP_W-1:0]  w_cur_gap_next;
  logic              w_err_next;
  logic [SPD_W-1:0]  w_speed_next;

  // Datapath wires
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_lfsr_unused;
  logic [GAP_W-1:0]  w_extra;
  logic              w_type_now;
  logic [SEL_W:0]    w_pick;
  logic              w_found;
  logic [SEL_W-1:0]  w_pick_idx;
  logic              w_stall;
  logic              w_fire_now;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (run),
    .o_state (w_lfsr)
  );

  // Only the type bit and the low random bits feed the scheduler.
  assign w_lfsr_unused = ^w_lfsr;
  assign w_extra       = GAP_W'(w_lfsr[RBITS-1:0]);

  // The type is drawn from the LFSR in the first PICK cycle, then held so a
  // stalled pick keeps retrying the same type.
  assign w_type_now = r_pick_first ? w_lfsr[LFSR_W-1] : r_type;
  assign w_pick     = pick_free(finish_i, w_type_now);
  assign w_found    = w_pick[SEL_W];
  assign w_pick_idx = w_pick[SEL_W-1:0];

  // Start pulse is suppressed in the same cycle that run drops or rst rises.
  assign w_fire_now = (r_state == ST_FIRE) && run && !rst;

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_start
    assign start_o[gi] = w_fire_now && (r_sel == SEL_W'(gi));
  end

  assign spawn_cnt = r_spawn_cnt;
  assign cur_gap   = r_cur_gap;
  assign stall     = w_stall;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_sel        <= '0;
      r_type       <= 1'b0;
      r_pick_first <= 1'b0;
      r_wait_cnt   <= '0;
      r_spawn_cnt  <= '0;
      r_cur_gap    <= P_MIN_GAP;
      r_err        <= 1'b0;
      r_speed_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_gap_cnt    <= w_gap_next;
      r_sel        <= w_sel_next;
      r_type       <= w_type_next;
      r_pick_first <= w_pick_first_next;
      r_wait_cnt   <= w_wait_next;
      r_spawn_cnt  <= w_spawn_next;
      r_cur_gap    <= w_cur_gap_next;
      r_err        <= w_err_next;
      r_speed_cnt  <= w_speed_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_gap_next        = r_gap_cnt;
    w_sel_next        = r_sel;
    w_type_next       = r_type;
    w_pick_first_next = 1'b0;
    w_wait_next       = r_wait_cnt;
    w_spawn_next      = r_spawn_cnt;
    w_cur_gap_next    = r_cur_gap;
    w_err_next        = r_err;
    w_speed_next      = r_speed_cnt;
    w_stall           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_next = ST_GAP;
          w_gap_next   = r_cur_gap + w_extra;
        end
      end

      ST_GAP: begin
        if (scroll_tick) begin
          w_gap_next = r_gap_cnt - 1'b1;
          if (r_gap_cnt <= P_GAP_ONE) begin
            w_state_next      = ST_PICK;
            w_pick_first_next = 1'b1;
          end
        end
      end

      ST_PICK: begin
        w_type_next = w_type_now;
        if (w_found) begin
          w_sel_next   = w_pick_idx;
          w_state_next = ST_FIRE;
        end else begin
          w_stall = 1'b1;
        end
      end

      ST_FIRE: begin
        w_wait_next  = '0;
        w_state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (!finish_i[r_sel]) begin
          // Launch confirmed. A saturated counter neither counts nor speeds up.
          if (r_spawn_cnt != P_CNT_MAX) begin
            w_spawn_next = r_spawn_cnt + 1'b1;
            if (r_speed_cnt == P_SPD_LAST) begin
              w_speed_next   = '0;
              w_cur_gap_next = (r_cur_gap >= P_FLOOR + P_STEP) ? (r_cur_gap - P_STEP) : P_FLOOR;
            end else begin
              w_speed_next = r_speed_cnt + 1'b1;
            end
          end
          // The freshly shortened minimum applies to this very reload.
          w_gap_next   = w_cur_gap_next + w_extra;
          w_state_next = ST_GAP;
        end else if (r_wait_cnt == P_WAIT_LAST) begin
          w_err_next   = 1'b1;
          w_gap_next   = r_cur_gap + w_extra;
          w_state_next = ST_GAP;
        end else begin
          w_wait_next = r_wait_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Dropping run abandons whatever is in flight; counters and err persist.
    if (!run) begin
      w_state_next      = ST_IDLE;
      w_pick_first_next = 1'b0;
    end
  end

endmodule
